// File: rtl/sr_drive_ctrl.sv
// ---------------------------------------------------------------------------
// sr_drive_ctrl
//
// Purpose:
//   Drives the S/R inputs of a downstream SR flip-flop with fixed-length
//   pulses, one command at a time. After each pulse, it checks the fed-back Q
//   against the state it expected. Mismatches are recorded in a sticky error
//   flag. An optional idle gap separates consecutive commands.
//
// Parameters:
//   PULSE_CYC  cycles S or R is held high per command (1..255)
//   GAP_CYC    idle cycles after each command's check (0..255)
//
// Ports:
//   clk_i        single clock, rising edge
//   rst_i        synchronous active-high reset; aborts any command in flight
//   req_valid_i  command request valid
//   req_op_i     command: 1 = set, 0 = clear
//   req_ready_o  command accepted this cycle if req_valid_i is high
//   s_o, r_o     registered set / reset drives to the flip-flop
//   q_fb_i       Q fed back from the flip-flop
//   q_exp_o      expected flip-flop state after the last accepted command
//   done_o       one-cycle pulse in the cycle after a check
//   err_o        sticky: q_fb_i differed from q_exp_o at a check
//   err_clr_i    clears err_o (a simultaneous mismatch takes priority)
// ---------------------------------------------------------------------------
module sr_drive_ctrl #(
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned GAP_CYC   = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_valid_i,
  input  logic req_op_i,
  output logic req_ready_o,
  output logic s_o,
  output logic r_o,
  input  logic q_fb_i,
  output logic q_exp_o,
  output logic done_o,
  output logic err_o,
  input  logic err_clr_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Counters are loaded with N-1 so that the state lasts exactly N cycles.
  // The gap reload value is never used when GAP_CYC is 0, so it is clamped
  // to avoid an out-of-range constant.
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] GAP_LD   = (GAP_CYC > 0) ? 8'(GAP_CYC - 1) : 8'd0;
  localparam bit         HAS_GAP  = (GAP_CYC > 0);

  state_t     state_q, state_d;
  logic [7:0] pcnt_q, pcnt_d;
  logic [7:0] gcnt_q, gcnt_d;
  logic       q_exp_q, q_exp_d;
  logic       s_q, s_d;
  logic       r_q, r_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       mismatch;

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    gcnt_d   = gcnt_q;
    q_exp_d  = q_exp_q;
    mismatch = 1'b0;

    case (state_q)
      IDLE: begin
        // Reset has priority in the register process. So req_ready_o's
        // dependence on rst_i does not need to be repeated here.
        if (req_valid_i) begin
          state_d = DRIVE;
          q_exp_d = req_op_i;
          pcnt_d  = PULSE_LD;
        end
      end
      DRIVE: begin
        if (pcnt_q == 8'd0) begin
          state_d = CHECK;
        end else begin
          pcnt_d = pcnt_q - 8'd1;
        end
      end
      CHECK: begin
        mismatch = (q_fb_i != q_exp_q);
        if (HAS_GAP) begin
          state_d = GAP;
          gcnt_d  = GAP_LD;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gcnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          gcnt_d = gcnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The drives are registered and derived from the next state. They are
    // therefore high for exactly the DRIVE cycles. Both depend on the same
    // q_exp_d bit, so S and R can never be high together.
    s_d    = (state_d == DRIVE) &&  q_exp_d;
    r_d    = (state_d == DRIVE) && !q_exp_d;
    done_d = (state_q == CHECK);

    if (mismatch) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pcnt_q  <= 8'd0;
      gcnt_q  <= 8'd0;
      q_exp_q <= 1'b0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      gcnt_q  <= gcnt_d;
      q_exp_q <= q_exp_d;
      s_q     <= s_d;
      r_q     <= r_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o = (state_q == IDLE) && !rst_i;
  assign s_o         = s_q;
  assign r_o         = r_q;
  assign q_exp_o     = q_exp_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sr_drive_ctrl
//
// Three instances with different pulse/gap settings:
//   (2,1), (3,0) and (1,0).
// Each instance drives a behavioural SR flip-flop. The feedback from that
// flip-flop can be randomly corrupted.
//
// The reference model tracks each command as a timeline. It records the
// cycle offset k from the accepting edge and derives the expected outputs
// from that offset:
//   - S/R are high for k in 1..P.
//   - The check edge ends cycle P+1.
//   - DONE is high at k = P+2.
//   - The controller is free again at k = P+G+2.
// ---------------------------------------------------------------------------
module tb_sr_drive_ctrl;

  localparam int N = 3;
  localparam int P_A [N] = '{2, 3, 1};
  localparam int G_A [N] = '{1, 0, 0};
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rst, valid, op, clr, flip;
  logic [N-1:0] q_ff = '0;
  wire  [N-1:0] q_fb = q_ff ^ flip;
  wire  [N-1:0] ready, s, r, qexp, done, err;

  sr_drive_ctrl #(.PULSE_CYC(2), .GAP_CYC(1)) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]), .req_valid_i(valid[0]), .req_op_i(op[0]),
    .req_ready_o(ready[0]), .s_o(s[0]), .r_o(r[0]), .q_fb_i(q_fb[0]),
    .q_exp_o(qexp[0]), .done_o(done[0]), .err_o(err[0]), .err_clr_i(clr[0])
  );
  sr_drive_ctrl #(.PULSE_CYC(3), .GAP_CYC(0)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]), .req_valid_i(valid[1]), .req_op_i(op[1]),
    .req_ready_o(ready[1]), .s_o(s[1]), .r_o(r[1]), .q_fb_i(q_fb[1]),
    .q_exp_o(qexp[1]), .done_o(done[1]), .err_o(err[1]), .err_clr_i(clr[1])
  );
  sr_drive_ctrl #(.PULSE_CYC(1), .GAP_CYC(0)) u_dut2 (
    .clk_i(clk), .rst_i(rst[2]), .req_valid_i(valid[2]), .req_op_i(op[2]),
    .req_ready_o(ready[2]), .s_o(s[2]), .r_o(r[2]), .q_fb_i(q_fb[2]),
    .q_exp_o(qexp[2]), .done_o(done[2]), .err_o(err[2]), .err_clr_i(clr[2])
  );

  // Downstream flip-flops.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (s[i])      q_ff[i] <= 1'b1;
      else if (r[i]) q_ff[i] <= 1'b0;
    end
  end

  // Reference model state.
  int m_k    [N];
  bit m_act  [N];
  bit m_op   [N];
  bit m_qexp [N];
  bit m_err  [N];
  bit m_done [N];

  always @(posedge clk) begin
    bit ce, mism;
    for (int i = 0; i < N; i++) begin
      ce   = 1'b0;
      mism = 1'b0;
      if (rst[i]) begin
        m_act[i]  = 1'b0;
        m_k[i]    = 0;
        m_qexp[i] = 1'b0;
        m_err[i]  = 1'b0;
        m_done[i] = 1'b0;
      end else begin
        if (m_act[i]) begin
          if (m_k[i] == P_A[i] + 1) begin
            ce   = 1'b1;
            mism = (q_fb[i] != m_op[i]);
          end
          m_k[i]++;
          if (m_k[i] == P_A[i] + G_A[i] + 2) m_act[i] = 1'b0;
        end else if (valid[i]) begin
          m_act[i]  = 1'b1;
          m_k[i]    = 1;
          m_op[i]   = op[i];
          m_qexp[i] = op[i];
        end
        if (mism)        m_err[i] = 1'b1;
        else if (clr[i]) m_err[i] = 1'b0;
        m_done[i] = ce;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    bit drv;
    rst   = '1;
    valid = '0;
    op    = '0;
    clr   = '0;
    flip  = '0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        drv = m_act[i] && (m_k[i] >= 1) && (m_k[i] <= P_A[i]);
        chk($sformatf("ready[%0d] c%0d", i, cyc), 32'(ready[i]), 32'(!m_act[i] && !rst[i]));
        chk($sformatf("s[%0d] c%0d", i, cyc), 32'(s[i]), 32'(drv && m_op[i]));
        chk($sformatf("r[%0d] c%0d", i, cyc), 32'(r[i]), 32'(drv && !m_op[i]));
        chk($sformatf("s_and_r[%0d] c%0d", i, cyc), 32'(s[i] & r[i]), 32'd0);
        chk($sformatf("done[%0d] c%0d", i, cyc), 32'(done[i]), 32'(m_done[i]));
        chk($sformatf("qexp[%0d] c%0d", i, cyc), 32'(qexp[i]), 32'(m_qexp[i]));
        chk($sformatf("err[%0d] c%0d", i, cyc), 32'(err[i]), 32'(m_err[i]));
      end
      // Phase 1: reset.
      // Phase 2: valid held high, with rare feedback faults.
      // Phase 3: everything random, including mid-command resets.
      for (int i = 0; i < N; i++) begin
        if (cyc < 3) begin
          rst[i]   = 1'b1;
          valid[i] = 1'b0;
          flip[i]  = 1'b0;
          clr[i]   = 1'b0;
        end else if (cyc < 800) begin
          rst[i]   = 1'b0;
          valid[i] = 1'b1;
          op[i]    = 1'($urandom_range(1, 0));
          flip[i]  = ($urandom_range(9, 0) == 0);
          clr[i]   = ($urandom_range(5, 0) == 0);
        end else begin
          rst[i]   = ($urandom_range(39, 0) == 0);
          valid[i] = 1'($urandom_range(1, 0));
          op[i]    = 1'($urandom_range(1, 0));
          flip[i]  = ($urandom_range(5, 0) == 0);
          clr[i]   = ($urandom_range(7, 0) == 0);
        end
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
